layer_sequencer: RTL and testbench

//  Top-level scheduler for the fully-connected inference chain (FC1..FCn).

---
 rtl/layer_sequencer_pkg.sv | 31 +++
 rtl/layer_sequencer_watchdog.sv | 37 +++
 rtl/layer_sequencer.sv | 141 ++++++++++++++
 tb/tb_layer_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/layer_sequencer_pkg.sv
//============================================================================
// Module : fc_seq_pkg
// Brief  : Shared state encoding, width helper and defaults for the FC
//          layer sequencer.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package fc_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LRST = 3'd1,
        S_RUN  = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } seq_state_t;

    localparam int c_def_rst_cycles = 2;
    localparam int c_def_timeout    = 200000;
    localparam int c_wdog_w         = 24;

    // Index width that never collapses to zero bits for a single element.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/layer_sequencer_watchdog.sv
//============================================================================
// Module : seq_watchdog
// Brief  : 24-bit run-cycle counter; flags the cycle where the count reaches
//          LIMIT-1.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module seq_watchdog
    import fc_seq_pkg::*;
#(
    parameter int LIMIT = c_def_timeout
) (
    input  logic clk,
    input  logic iRst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [c_wdog_w-1:0] c_last = c_wdog_w'(LIMIT - 1);

    logic [c_wdog_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!iRst_n || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + c_wdog_w'(1);
        end
    end

    assign expired = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/layer_sequencer.sv
//============================================================================
// Module : layer_sequencer
// Brief  : Runs FC layers strictly in order, granting one layer at a time
//          the shared resources, with watchdog, overflow capture and abort.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module layer_sequencer
    import fc_seq_pkg::*;
#(
    parameter int NUM_LAYERS     = 3,
    parameter int LW             = idx_width(NUM_LAYERS),
    parameter int RST_CYCLES     = c_def_rst_cycles,
    parameter int TIMEOUT_CYCLES = c_def_timeout
) (
    input  logic                  clk,
    input  logic                  iRst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_done,
    input  logic [NUM_LAYERS-1:0] layer_overflow,
    output logic [NUM_LAYERS-1:0] layer_ena,
    output logic [NUM_LAYERS-1:0] layer_rst_n,
    output logic [LW-1:0]         sel,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [NUM_LAYERS-1:0] ovf_mask,
    output logic                  timeout
);

    localparam int                c_rcw      = idx_width(RST_CYCLES);
    localparam logic [LW-1:0]     c_last     = LW'(NUM_LAYERS - 1);
    localparam logic [c_rcw-1:0]  c_rst_last = c_rcw'(RST_CYCLES - 1);

    seq_state_t            r_state, w_state_nxt;
    logic [LW-1:0]         r_cur, w_cur_nxt;
    logic [c_rcw-1:0]      r_rcnt, w_rcnt_nxt;
    logic [NUM_LAYERS-1:0] r_ovf, w_ovf_nxt;
    logic                  r_timeout, w_timeout_nxt;
    logic                  w_in_run;
    logic                  w_wdog_exp;
    logic [NUM_LAYERS-1:0] w_onehot;

    assign w_in_run = (r_state == S_RUN);

    // Counter is held clear outside RUN, so every layer starts from zero.
    seq_watchdog #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .iRst_n  (iRst_n),
        .clr     (!w_in_run),
        .en      (w_in_run),
        .expired (w_wdog_exp)
    );

    always_ff @(posedge clk) begin
        if (!iRst_n) begin
            r_state   <= S_IDLE;
            r_cur     <= '0;
            r_rcnt    <= '0;
            r_ovf     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur     <= w_cur_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_ovf     <= w_ovf_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cur_nxt     = r_cur;
        w_rcnt_nxt    = r_rcnt;
        w_ovf_nxt     = r_ovf;
        w_timeout_nxt = r_timeout;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_state_nxt   = S_LRST;
                    w_cur_nxt     = '0;
                    w_rcnt_nxt    = '0;
                    w_ovf_nxt     = '0;
                    w_timeout_nxt = 1'b0;
                end
            end
            S_LRST: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_rcnt == c_rst_last) begin
                    w_state_nxt = S_RUN;
                    w_rcnt_nxt  = '0;
                end else begin
                    w_rcnt_nxt = r_rcnt + c_rcw'(1);
                end
            end
            S_RUN: begin
                // A done arriving on the last allowed cycle still counts.
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (layer_done[r_cur]) begin
                    w_ovf_nxt[r_cur] = layer_overflow[r_cur];
                    w_state_nxt      = S_GAP;
                end else if (w_wdog_exp) begin
                    w_state_nxt   = S_ERR;
                    w_timeout_nxt = 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cur == c_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cur_nxt   = r_cur + LW'(1);
                    w_rcnt_nxt  = '0;
                    w_state_nxt = S_LRST;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decode registered state only; no input-to-output paths.
    assign w_onehot    = NUM_LAYERS'(1) << r_cur;
    assign layer_ena   = (r_state == S_LRST || w_in_run) ? w_onehot : '0;
    assign layer_rst_n = w_in_run ? w_onehot : '0;
    assign sel         = r_cur;
    assign busy        = (r_state == S_LRST) || w_in_run || (r_state == S_GAP);
    assign done        = (r_state == S_DONE);
    assign ovf_mask    = r_ovf;
    assign overflow    = |r_ovf;
    assign timeout     = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_layer_sequencer.sv
//============================================================================
// Module : tb_layer_sequencer
// Brief  : Cycle-by-cycle check of layer_sequencer against a pass-plan model.
// Rev    : 1.0  initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_layer_sequencer;

    localparam int N  = 3;
    localparam int LW = 2;
    localparam int RC = 2;
    localparam int TO = 64;

    logic          clk;
    logic          iRst_n;
    logic          start;
    logic          abort;
    logic [N-1:0]  layer_done;
    logic [N-1:0]  layer_overflow;
    logic [N-1:0]  layer_ena;
    logic [N-1:0]  layer_rst_n;
    logic [LW-1:0] sel;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [N-1:0]  ovf_mask;
    logic          timeout;

    layer_sequencer #(
        .NUM_LAYERS     (N),
        .LW             (LW),
        .RST_CYCLES     (RC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .iRst_n         (iRst_n),
        .start          (start),
        .abort          (abort),
        .layer_done     (layer_done),
        .layer_overflow (layer_overflow),
        .layer_ena      (layer_ena),
        .layer_rst_n    (layer_rst_n),
        .sel            (sel),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .ovf_mask       (ovf_mask),
        .timeout        (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pass-plan model: which layer owns the bus, which phase, how long so far.
    typedef enum int {P_IDLE, P_RSTH, P_RUN, P_GAP, P_FIN, P_ERR} phase_t;
    phase_t       m_ph;
    int           m_layer;
    int           m_cnt;
    logic [N-1:0] m_ovf;
    bit           m_to;
    int           m_delay [N];
    bit           stale_one;
    bit           ovf_use_fixed;
    logic [N-1:0] ovf_fixed;

    task automatic tick(input bit st, input bit ab, input bit rn);
        logic [N-1:0] oh, e_ena, e_rstn, d, o;
        bit           owns, b;
        oh = '0;
        oh[m_layer] = 1'b1;
        owns   = (m_ph == P_RSTH) || (m_ph == P_RUN);
        e_ena  = owns ? oh : '0;
        e_rstn = (m_ph == P_RUN) ? oh : '0;
        b      = (m_ph == P_RSTH) || (m_ph == P_RUN) || (m_ph == P_GAP);
        chk("layer_ena", 32'(layer_ena), 32'(e_ena));
        chk("layer_rst_n", 32'(layer_rst_n), 32'(e_rstn));
        chk("sel", 32'(sel), 32'(m_layer));
        chk("busy_done_ovf_to", 32'({busy, done, overflow, timeout}),
            32'({b, (m_ph == P_FIN), (|m_ovf), m_to}));
        chk("ovf_mask", 32'(ovf_mask), 32'(m_ovf));

        d = N'($urandom);
        o = ovf_use_fixed ? ovf_fixed : N'($urandom);
        if (m_ph == P_RSTH && stale_one) d[m_layer] = 1'b1;
        if (m_ph == P_RUN) d[m_layer] = (m_cnt + 1 == m_delay[m_layer]);
        start          = st;
        abort          = ab;
        iRst_n         = rn;
        layer_done     = d;
        layer_overflow = o;

        if (!rn) begin
            m_ph = P_IDLE; m_layer = 0; m_cnt = 0; m_ovf = '0; m_to = 1'b0;
        end else begin
            case (m_ph)
                P_IDLE, P_FIN, P_ERR: begin
                    if (st) begin
                        m_ph = P_RSTH; m_layer = 0; m_cnt = 0; m_ovf = '0; m_to = 1'b0;
                    end
                end
                P_RSTH: begin
                    if (ab) m_ph = P_IDLE;
                    else begin
                        m_cnt++;
                        if (m_cnt == RC) begin m_ph = P_RUN; m_cnt = 0; end
                    end
                end
                P_RUN: begin
                    if (ab) m_ph = P_IDLE;
                    else begin
                        m_cnt++;
                        if (d[m_layer]) begin
                            m_ovf[m_layer] = o[m_layer];
                            m_ph = P_GAP;
                        end else if (m_cnt == TO) begin
                            m_ph = P_ERR; m_to = 1'b1;
                        end
                    end
                end
                P_GAP: begin
                    if (ab) m_ph = P_IDLE;
                    else if (m_layer == N - 1) m_ph = P_FIN;
                    else begin m_layer++; m_cnt = 0; m_ph = P_RSTH; end
                end
                default: m_ph = P_IDLE;
            endcase
        end
        @(negedge clk);
    endtask

    // One pass: per-layer RUN length until done, optional abort/reset at a RUN cycle.
    task automatic run_pass(input int d0, input int d1, input int d2, input bit hold,
                            input int ab_l, input int ab_c, input int rs_l, input int rs_c);
        int guard;
        bit ab, rn;
        m_delay[0] = d0;
        m_delay[1] = d1;
        m_delay[2] = d2;
        tick(1'b1, 1'b0, 1'b1);
        guard = 0;
        while (m_ph inside {P_RSTH, P_RUN, P_GAP}) begin
            ab = (m_ph == P_RUN) && (m_layer == ab_l) && (m_cnt == ab_c);
            rn = !((m_ph == P_RUN) && (m_layer == rs_l) && (m_cnt == rs_c));
            tick(hold || ($urandom_range(0, 7) == 0), ab, rn);
            guard++;
            if (guard > 1000) begin
                chk("pass_bound", 32'(guard), 32'(0));
                break;
            end
        end
        repeat (3) tick(1'b0, 1'($urandom_range(0, 1)), 1'b1);
    endtask

    function automatic int rand_delay();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return TO + int'($urandom_range(1, 5));
        if (r == 1) return TO;
        return int'($urandom_range(1, 20));
    endfunction

    initial begin
        start = 1'b0; abort = 1'b0; iRst_n = 1'b0;
        layer_done = '0; layer_overflow = '0;
        stale_one = 1'b0; ovf_use_fixed = 1'b1; ovf_fixed = '0;
        m_ph = P_IDLE; m_layer = 0; m_cnt = 0; m_ovf = '0; m_to = 1'b0;
        @(negedge clk);
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        repeat (2) tick(1'b0, 1'b1, 1'b1);

        run_pass(50, 50, 50, 1'b0, -1, 0, -1, 0);
        ovf_fixed = 3'b010;
        run_pass(10, 20, 30, 1'b0, -1, 0, -1, 0);
        ovf_fixed = 3'b000;
        run_pass(5, 5, 5, 1'b0, -1, 0, -1, 0);
        ovf_use_fixed = 1'b0;
        run_pass(TO + 10, 1, 1, 1'b0, -1, 0, -1, 0);
        run_pass(8, 12, 9, 1'b0, 1, 5, -1, 0);
        stale_one = 1'b1;
        run_pass(7, 7, 7, 1'b1, -1, 0, -1, 0);
        stale_one = 1'b0;
        run_pass(9, 9, 40, 1'b0, -1, 0, 2, 5);
        run_pass(TO, 3, TO, 1'b0, -1, 0, -1, 0);

        for (int i = 0; i < 25; i++) begin
            int al, ac, rl, rc;
            al = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            ac = int'($urandom_range(0, 6));
            rl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            rc = int'($urandom_range(0, 6));
            stale_one = 1'($urandom_range(0, 1));
            run_pass(rand_delay(), rand_delay(), rand_delay(),
                     1'($urandom_range(0, 3) == 0), al, ac, rl, rc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete, got %0d failures so far", n_fail);
        $fatal(1, "time limit reached");
    end

endmodule

`default_nettype wire
